sram_tiled_1rw1r: RTL and testbench

//  Parametrised 1-write/1-read SRAM built by tiling sky130_sram_1kbyte_1rw1r_32x256_8 macros:

---
 rtl/sram_tiled_1rw1r.sv | 155 +++++++++++++++
 tb/tb_sram_tiled_1rw1r.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sram_tiled_1rw1r.sv
// sram_tiled_1rw1r: tiled 1W/1R SRAM with zero-fill init, 2-stage read pipeline and collision stall.
// Define SRAM_BYPASS_EN to forward full-mask same-address writes to the colliding read instead of stalling.

module sram_macro_32x256 (
    input  logic        clk,
    input  logic        csb0,
    input  logic [3:0]  wmask0,
    input  logic [7:0]  addr0,
    input  logic [31:0] din0,
    input  logic        csb1,
    input  logic [7:0]  addr1,
    output logic [31:0] dout1
);
    // behavioural stand-in for sky130_sram_1kbyte_1rw1r_32x256_8: address latched at N, dout updated at N+1
    logic [31:0] mem [256];
    logic        rd_q;
    logic [7:0]  addr_q;
    always_ff @(posedge clk) begin
        if (!csb0)
            for (int j = 0; j < 4; j++)
                if (wmask0[j]) mem[addr0][8*j +: 8] <= din0[8*j +: 8];
        rd_q   <= !csb1;
        addr_q <= addr1;
        if (rd_q) dout1 <= mem[addr_q];
    end
endmodule

module sram_tiled_1rw1r #(
    parameter int DATA_WIDTH  = 72,
    parameter int ADDR_WIDTH  = 9,
    parameter int WMASK_WIDTH = DATA_WIDTH/8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_en,
    output logic                   write_ready,
    input  logic [ADDR_WIDTH-1:0]  write_addr,
    input  logic [WMASK_WIDTH-1:0] write_mask,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   read_en,
    output logic                   read_ready,
    input  logic [ADDR_WIDTH-1:0]  read_addr,
    output logic                   read_valid,
    output logic [DATA_WIDTH-1:0]  read_data,
    output logic                   init_done,
    output logic                   collision
);
    localparam int COLS  = (DATA_WIDTH + 31) / 32;
    localparam int BANKS = 1 << (ADDR_WIDTH - 8);
    localparam int PW    = COLS * 32;
    localparam int MW    = COLS * 4;
    localparam int BW    = ADDR_WIDTH > 8 ? ADDR_WIDTH - 8 : 1;
    localparam logic [0:0] INIT = 1'b0, IDLE = 1'b1;

    logic [0:0]            state;
    logic [7:0]            fill_cnt;
    logic                  init, idle, hit, full, byp, stall, wr_fire, rd_fire;
    logic [BW-1:0]         wbank, rbank, bank_q1, bank_q2;
    logic [PW-1:0]         wpad;
    logic [MW-1:0]         mpad, fmask;
    logic [BANKS-1:0][PW-1:0] dout;
    logic                  v1, v2, byp1, byp2;
    logic [DATA_WIDTH-1:0] byp_d1, byp_d2;
    logic                  unused_dout;

    assign init        = state == INIT;
    assign idle        = state == IDLE;
    assign wpad        = PW'(write_data);
    assign mpad        = MW'(write_mask);
    assign fmask       = MW'({WMASK_WIDTH{1'b1}});
    assign unused_dout = ^dout;

    generate
        if (ADDR_WIDTH > 8) begin : g_split
            assign wbank = write_addr[ADDR_WIDTH-1:8];
            assign rbank = read_addr[ADDR_WIDTH-1:8];
        end else begin : g_nosplit
            assign wbank = '0;
            assign rbank = '0;
        end
    endgenerate

    assign hit  = idle && write_en && read_en && write_addr == read_addr && |write_mask;
    assign full = &write_mask;
`ifdef SRAM_BYPASS_EN
    assign byp   = hit && full;
    assign stall = hit && !full;
`else
    assign byp   = 1'b0;
    assign stall = hit;
`endif
    assign write_ready = idle;
    assign read_ready  = idle && !stall;
    assign collision   = stall;
    assign init_done   = idle;
    assign wr_fire     = idle && write_en;
    assign rd_fire     = read_en && read_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            fill_cnt <= '0;
        end else if (init) begin
            fill_cnt <= fill_cnt + 8'd1;
            if (fill_cnt == 8'hFF) state <= IDLE;
        end
    end

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            logic wsel, rsel;
            assign wsel = init || (wr_fire && |write_mask && wbank == BW'(b));
            assign rsel = rd_fire && !byp && rbank == BW'(b);
            for (genvar c = 0; c < COLS; c++) begin : g_col
                sram_macro_32x256 u_mac (
                    .clk   (clk),
                    .csb0  (!wsel),
                    .wmask0(init ? fmask[4*c +: 4] : mpad[4*c +: 4]),
                    .addr0 (init ? fill_cnt : write_addr[7:0]),
                    .din0  (init ? 32'd0 : wpad[32*c +: 32]),
                    .csb1  (!rsel),
                    .addr1 (read_addr[7:0]),
                    .dout1 (dout[b][32*c +: 32])
                );
            end
        end
    endgenerate

    // stage 1 tracks the macro address latch, stage 2 the macro dout update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            byp1       <= 1'b0;
            byp2       <= 1'b0;
            bank_q1    <= '0;
            bank_q2    <= '0;
            byp_d1     <= '0;
            byp_d2     <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            v1         <= rd_fire;
            byp1       <= byp;
            bank_q1    <= rbank;
            byp_d1     <= byp ? write_data : byp_d1;
            v2         <= v1;
            byp2       <= byp1;
            bank_q2    <= bank_q1;
            byp_d2     <= byp_d1;
            read_valid <= v2;
            if (v2) read_data <= byp2 ? byp_d2 : dout[bank_q2][DATA_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_sram_tiled_1rw1r.sv
// tb_sram_tiled_1rw1r: random and directed traffic against an array model, with a read-result scoreboard.
module tb_sram_tiled_1rw1r;
    logic        clk = 1'b0;
    logic        rst;
    logic        write_en, read_en;
    logic        write_ready, read_ready, read_valid, init_done, collision;
    logic [8:0]  write_addr, read_addr, write_mask;
    logic [71:0] write_data, read_data;

    logic [71:0] mem [512];
    logic [71:0] q [$];
    logic [71:0] last;
    logic        acc;
    int          total = 0, passed = 0;

    sram_tiled_1rw1r dut (
        .clk(clk), .rst(rst), .write_en(write_en), .write_ready(write_ready),
        .write_addr(write_addr), .write_mask(write_mask), .write_data(write_data),
        .read_en(read_en), .read_ready(read_ready), .read_addr(read_addr),
        .read_valid(read_valid), .read_data(read_data), .init_done(init_done),
        .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) last = '0;
        else if (read_valid) begin
            if (q.size() == 0) chk("spurious read_valid", {71'd0, read_valid}, 72'd0);
            else chk("read_data", read_data, q.pop_front());
            last = read_data;
        end else chk("read_data hold", read_data, last);
    end

    task automatic step(input logic w, input logic [8:0] wa, input logic [8:0] m, input logic [71:0] d,
                        input logic r, input logic [8:0] ra);
        logic exp_stall;
        @(negedge clk);
        #1;
        write_en = w; write_addr = wa; write_mask = m; write_data = d;
        read_en = r; read_addr = ra;
        #1;
        exp_stall = w && r && wa == ra && m != 9'd0;
`ifdef SRAM_BYPASS_EN
        if (m == 9'h1FF) exp_stall = 1'b0;
`endif
        if (r) begin
            chk("collision", {71'd0, collision}, {71'd0, exp_stall});
            chk("read_ready", {71'd0, read_ready}, {71'd0, !exp_stall});
        end
        if (w) begin
            chk("write_ready", {71'd0, write_ready}, 72'd1);
            if (write_ready)
                for (int i = 0; i < 9; i++) if (m[i]) mem[wa][8*i +: 8] = d[8*i +: 8];
        end
        acc = r && read_ready;
        if (acc) q.push_back(mem[ra]);
    endtask

    task automatic idle_in();
        write_en = 1'b0; read_en = 1'b0; write_addr = '0; read_addr = '0; write_mask = '0; write_data = '0;
    endtask

    task automatic wait_init();
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 10) chk("init readies", {70'd0, write_ready, read_ready}, 72'd0);
        end while (!init_done && cnt < 400);
        chk("init cycles", 72'(cnt), 72'd256);
        foreach (mem[i]) mem[i] = '0;
        idle_in();
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("queue drained", 72'(q.size()), 72'd0);
    endtask

    task automatic reset_zero_check(input string name);
        #1;
        chk(name, {read_valid, read_data[70:0]}, 72'd0);
        chk({name, " flags"}, {67'd0, read_data[71], write_ready, read_ready, init_done, collision}, 72'd0);
    endtask

    initial begin
        logic [8:0]  wa, ra, m;
        logic [71:0] d;
        logic [2:0]  v;
        int          k;
        idle_in();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_zero_check("reset outputs");
        // requests held during init must be ignored
        write_en = 1'b1; write_mask = 9'h1FF; write_data = '1; read_en = 1'b1;
        rst = 1'b0;
        wait_init();

        for (int a = 0; a < 512; a++) step(0, 0, 0, 0, 1, 9'(a));
        step(0, 0, 0, 0, 0, 0);
        drain();

        step(1, 9'h1A5, 9'h1FF, 72'h12_3456789A_BCDEF012, 0, 0);
        step(0, 0, 0, 0, 1, 9'h1A5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            v[2-i] = read_valid;
            if (i == 0) idle_in();
        end
        chk("read latency", {69'd0, v}, 72'd1);

        step(1, 9'h005, 9'h003, '1, 0, 0);
        step(0, 0, 0, 0, 1, 9'h005);
        chk("partial mask model", mem[5], 72'h00_00000000_0000FFFF);

        for (int i = 0; i < 16; i++) begin
            step(1, 9'h110 + 9'(i), 9'h1FF, {$urandom, $urandom, 8'hB1}, 0, 0);
            step(1, 9'h010 + 9'(i), 9'h1FF, {$urandom, $urandom, 8'h0A}, 0, 0);
        end
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 9'h010 + 9'(i));
        step(0, 0, 0, 0, 0, 0);
        drain();

        step(1, 9'h044, 9'h1FF, 72'hA5_DEADBEEF_CAFEF00D, 1, 9'h044);
        if (!acc) step(0, 0, 0, 0, 1, 9'h044);
        step(1, 9'h044, 9'h0F0, 72'h5A_0123456789ABCDEF, 1, 9'h044);
        chk("partial collision stalls", {71'd0, collision}, 72'd1);
        if (!acc) step(0, 0, 0, 0, 1, 9'h044);
        step(0, 0, 0, 0, 0, 0);
        drain();

        for (int n = 0; n < 1500; n++) begin
            wa = 9'($urandom_range(0, 1)) * 9'd256 + 9'($urandom_range(0, 7));
            ra = 9'($urandom_range(0, 1)) * 9'd256 + 9'($urandom_range(0, 7));
            k  = $urandom_range(0, 9);
            m  = k < 3 ? 9'h1FF : (k == 3 ? 9'h000 : 9'($urandom));
            d  = {$urandom, $urandom, 8'($urandom)};
            step($urandom_range(0, 1) == 1, wa, m, d, $urandom_range(0, 9) < 6, ra);
        end
        step(0, 0, 0, 0, 0, 0);
        drain();

        step(1, 9'h1F0, 9'h1FF, 72'hFF_FFFFFFFF_FFFFFFFF, 0, 0);
        step(0, 0, 0, 0, 1, 9'h1F0);
        step(0, 0, 0, 0, 1, 9'h1F0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        reset_zero_check("rst during reads");
        idle_in();
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        rst = 1'b1;
        reset_zero_check("rst mid init");
        @(negedge clk);
        #1;
        rst = 1'b0;
        wait_init();
        for (int n = 0; n < 40; n++)
            step($urandom_range(0, 1) == 1, 9'($urandom_range(0, 15)), 9'($urandom), {$urandom, $urandom, 8'($urandom)},
                 1'b1, 9'($urandom_range(0, 15)));
        step(0, 0, 0, 0, 0, 0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
